frame_reader: RTL and testbench

- Wishbone read master on sys_clk. Streams the framebuffer (HDISP×VDISP pixels, one 32-bit word per pixel, RGB in bits 23:0) out of SDRAM, in raster order.
- Pushes each word into the write side of the pixel FIFO that feeds the vga display stage.
- Takes ownership of the SDRAM Wishbone bus that is currently tied off in the top level.
- Wraps continuously frame after frame, with flow control from the FIFO almost-full flag.

---
 rtl/video_pkg.sv | 25 ++
 rtl/fb_addr_counter.sv | 36 +++
 rtl/frame_reader.sv | 99 +++++++++
 tb/tb_frame_reader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video definitions: frame geometry defaults, pixel word layout,
// and the frame reader state encoding.
package video_pkg;

    localparam int HDISP_DEF = 800;
    localparam int VDISP_DEF = 480;

    localparam int PIX_R_MSB = 23;
    localparam int PIX_R_LSB = 16;
    localparam int PIX_G_MSB = 15;
    localparam int PIX_G_LSB = 8;
    localparam int PIX_B_MSB = 7;
    localparam int PIX_B_LSB = 0;

    typedef enum logic {
        S_WAIT = 1'b0,
        S_READ = 1'b1
    } state_t;

    // Index width for a frame of n pixels; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fb_addr_counter.sv
// Raster pixel index with end-of-frame wrap and a registered
// one-cycle frame_done pulse.
module fb_addr_counter
    import video_pkg::*;
#(
    parameter int HDISP = HDISP_DEF,
    parameter int VDISP = VDISP_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             inc,
    output logic [idx_w(HDISP*VDISP)-1:0]    idx,
    output logic                             frame_done
);

    localparam int NPIX = HDISP * VDISP;
    localparam int IW   = idx_w(NPIX);
    localparam logic [IW-1:0] LAST = IW'(NPIX - 1);

    logic last;

    assign last = (idx == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= inc && last;
            if (inc) begin
                idx <= last ? '0 : idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_reader.sv
// Wishbone read master streaming the framebuffer in raster order
// into the pixel FIFO, throttled by the FIFO almost-full flag.
module frame_reader
    import video_pkg::*;
#(
    parameter int          HDISP   = HDISP_DEF,
    parameter int          VDISP   = VDISP_DEF,
    parameter logic [31:0] FB_BASE = 32'h0
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    output logic        wshb_cyc,
    output logic        wshb_stb,
    output logic        wshb_we,
    output logic [31:0] wshb_adr,
    output logic [3:0]  wshb_sel,
    output logic [2:0]  wshb_cti,
    output logic [1:0]  wshb_bte,
    input  logic [31:0] wshb_dat_sm,
    input  logic        wshb_ack,
    input  logic        wshb_err,
    input  logic        wshb_rty,
    output logic [31:0] fifo_wdata,
    output logic        fifo_write,
    input  logic        fifo_walmost_full,
    output logic        frame_done
);

    localparam int IW = idx_w(HDISP * VDISP);

    state_t          state;
    logic [IW-1:0]   idx;
    logic            push;
    logic            fail;
    logic            inc;

    assign wshb_we  = 1'b0;
    assign wshb_sel = 4'hF;
    assign wshb_cti = 3'b000;
    assign wshb_bte = 2'b00;

    assign wshb_adr = FB_BASE + (32'(idx) << 2);

    // err and rty both terminate without data and outrank ack.
    assign fail = wshb_err || wshb_rty;
    assign inc  = (state == S_READ) && wshb_ack && !fail;

    // A push registered just before reset must not reach the FIFO.
    assign fifo_write = push && !sys_rst;

    fb_addr_counter #(
        .HDISP (HDISP),
        .VDISP (VDISP)
    ) u_cnt (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .inc        (inc),
        .idx        (idx),
        .frame_done (frame_done)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= S_WAIT;
            wshb_cyc   <= 1'b0;
            wshb_stb   <= 1'b0;
            push       <= 1'b0;
            fifo_wdata <= '0;
        end else begin
            push <= 1'b0;
            unique case (state)
                S_WAIT: begin
                    if (!fifo_walmost_full) begin
                        state    <= S_READ;
                        wshb_cyc <= 1'b1;
                        wshb_stb <= 1'b1;
                    end
                end
                S_READ: begin
                    if (fail) begin
                        state    <= S_WAIT;
                        wshb_cyc <= 1'b0;
                        wshb_stb <= 1'b0;
                    end else if (wshb_ack) begin
                        push       <= 1'b1;
                        fifo_wdata <= wshb_dat_sm;
                        if (fifo_walmost_full) begin
                            state    <= S_WAIT;
                            wshb_cyc <= 1'b0;
                            wshb_stb <= 1'b0;
                        end
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader on a small 8x6 frame at a non-zero
// framebuffer base; inputs change on negedge, outputs checked on negedge.
module tb_frame_reader;

    localparam int          H    = 8;
    localparam int          V    = 6;
    localparam int          NPIX = H * V;
    localparam logic [31:0] B    = 32'h0000_1000;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        wshb_cyc, wshb_stb, wshb_we;
    logic [31:0] wshb_adr;
    logic [3:0]  wshb_sel;
    logic [2:0]  wshb_cti;
    logic [1:0]  wshb_bte;
    logic [31:0] wshb_dat_sm = '0;
    logic        wshb_ack = 1'b0;
    logic        wshb_err = 1'b0;
    logic        wshb_rty = 1'b0;
    logic [31:0] fifo_wdata;
    logic        fifo_write;
    logic        fifo_walmost_full = 1'b0;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int pushes = 0;
    int exp_pushes = 0;
    int fd_pulses = 0;

    typedef struct {
        logic [31:0] dat;
        int          dly;
        logic        af;
        logic [1:0]  rsp;
        logic [31:0] adr;
    } vec_t;

    vec_t tbl[10];

    frame_reader #(
        .HDISP   (H),
        .VDISP   (V),
        .FB_BASE (B)
    ) dut (
        .sys_clk           (sys_clk),
        .sys_rst           (sys_rst),
        .wshb_cyc          (wshb_cyc),
        .wshb_stb          (wshb_stb),
        .wshb_we           (wshb_we),
        .wshb_adr          (wshb_adr),
        .wshb_sel          (wshb_sel),
        .wshb_cti          (wshb_cti),
        .wshb_bte          (wshb_bte),
        .wshb_dat_sm       (wshb_dat_sm),
        .wshb_ack          (wshb_ack),
        .wshb_err          (wshb_err),
        .wshb_rty          (wshb_rty),
        .fifo_wdata        (fifo_wdata),
        .fifo_write        (fifo_write),
        .fifo_walmost_full (fifo_walmost_full),
        .frame_done        (frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    // Push/pulse tally and bus rules, sampled just before each edge.
    always @(posedge sys_clk) begin
        if (fifo_write) pushes++;
        if (frame_done) fd_pulses++;
        if (wshb_stb === 1'b1 && wshb_cyc !== 1'b1) begin
            errors++;
            $display("FAIL stb_without_cyc at %0t", $time);
        end
        if (fifo_write === 1'b1 && sys_rst) begin
            errors++;
            $display("FAIL push_in_reset at %0t", $time);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wait_stb(input string nm);
        int n = 0;
        while (!(wshb_cyc && wshb_stb) && n < 40) begin
            @(negedge sys_clk);
            n++;
        end
        chk({nm, " stb"}, 32'(wshb_stb), 32'd1);
    endtask

    task automatic do_ack(input logic [31:0] d, input logic [31:0] a,
                          input string nm);
        wait_stb(nm);
        chk({nm, " adr"}, wshb_adr, a);
        wshb_dat_sm = d;
        wshb_ack    = 1'b1;
        @(negedge sys_clk);
        wshb_ack = 1'b0;
        exp_pushes++;
        chk({nm, " push"}, 32'(fifo_write), 32'd1);
        chk({nm, " data"}, fifo_wdata, d);
    endtask

    initial begin
        bit ok;

        tbl[0] = '{32'h00AABBCC, 2, 1'b0, 2'd0, B};
        tbl[1] = '{32'h11111111, 1, 1'b0, 2'd0, B + 32'd4};
        tbl[2] = '{32'h22222222, 1, 1'b1, 2'd0, B + 32'd8};
        tbl[3] = '{32'h33333333, 0, 1'b0, 2'd0, B + 32'd12};
        tbl[4] = '{32'h44444444, 0, 1'b0, 2'd0, B + 32'd16};
        tbl[5] = '{32'hDEAD0005, 0, 1'b0, 2'd1, B + 32'd20};
        tbl[6] = '{32'hDEAD0006, 1, 1'b0, 2'd2, B + 32'd20};
        tbl[7] = '{32'h5555AAAA, 0, 1'b0, 2'd0, B + 32'd20};
        tbl[8] = '{32'hDEAD0008, 0, 1'b0, 2'd3, B + 32'd24};
        tbl[9] = '{32'h66666666, 0, 1'b0, 2'd0, B + 32'd24};

        repeat (3) begin
            @(negedge sys_clk);
            chk("rst cyc", 32'(wshb_cyc), 32'd0);
            chk("rst stb", 32'(wshb_stb), 32'd0);
            chk("rst push", 32'(fifo_write), 32'd0);
            chk("rst done", 32'(frame_done), 32'd0);
        end
        sys_rst = 1'b0;
        chk("rst adr", wshb_adr, B);

        for (int k = 0; k < 10; k++) begin
            vec_t  v;
            string nm;
            v  = tbl[k];
            nm = $sformatf("vec%0d", k);
            wait_stb(nm);
            for (int d = 0; d < v.dly; d++) begin
                @(negedge sys_clk);
                chk({nm, " hold adr"}, wshb_adr, v.adr);
                chk({nm, " idle push"}, 32'(fifo_write), 32'd0);
            end
            chk({nm, " adr"}, wshb_adr, v.adr);
            wshb_dat_sm       = v.dat;
            fifo_walmost_full = v.af;
            wshb_ack = (v.rsp == 2'd0) || (v.rsp == 2'd3);
            wshb_err = (v.rsp == 2'd1) || (v.rsp == 2'd3);
            wshb_rty = (v.rsp == 2'd2) || (v.rsp == 2'd3);
            @(negedge sys_clk);
            wshb_ack = 1'b0;
            wshb_err = 1'b0;
            wshb_rty = 1'b0;
            if (v.rsp == 2'd0) begin
                exp_pushes++;
                chk({nm, " push"}, 32'(fifo_write), 32'd1);
                chk({nm, " data"}, fifo_wdata, v.dat);
                chk({nm, " next adr"}, wshb_adr, v.adr + 32'd4);
            end else begin
                chk({nm, " no push"}, 32'(fifo_write), 32'd0);
                chk({nm, " gap cyc"}, 32'(wshb_cyc), 32'd0);
                chk({nm, " keep adr"}, wshb_adr, v.adr);
                @(negedge sys_clk);
                chk({nm, " reissue stb"}, 32'(wshb_stb), 32'd1);
                chk({nm, " reissue adr"}, wshb_adr, v.adr);
            end
            if (v.af) begin
                chk({nm, " bp cyc"}, 32'(wshb_cyc), 32'd0);
                ok = 1'b1;
                repeat (10) begin
                    @(negedge sys_clk);
                    if (wshb_cyc || fifo_write) ok = 1'b0;
                end
                chk({nm, " bp hold"}, 32'(ok), 32'd1);
                fifo_walmost_full = 1'b0;
            end
        end

        // Run through the end of frame and into pixel 0 of the next one.
        for (int i = 7; i <= NPIX; i++) begin
            do_ack(32'hA500_0000 | 32'(i), B + 32'(4 * (i % NPIX)),
                   $sformatf("wrap%0d", i));
            chk($sformatf("wrap%0d done", i), 32'(frame_done),
                32'(i == NPIX - 1));
        end
        chk("frame pulses", 32'(fd_pulses), 32'd1);

        // Reset just after pixel 37 is acked: its push must be dropped.
        for (int i = 1; i <= 37; i++) begin
            do_ack(32'hB600_0000 | 32'(i), B + 32'(4 * i),
                   $sformatf("mid%0d", i));
        end
        sys_rst = 1'b1;
        exp_pushes--;
        #1;
        chk("mid rst push gated", 32'(fifo_write), 32'd0);
        @(negedge sys_clk);
        chk("mid rst cyc", 32'(wshb_cyc), 32'd0);
        chk("mid rst stb", 32'(wshb_stb), 32'd0);
        chk("mid rst push", 32'(fifo_write), 32'd0);
        chk("mid rst adr", wshb_adr, B);
        sys_rst = 1'b0;
        do_ack(32'hCAFE0001, B, "restart");

        @(negedge sys_clk);
        chk("push total", 32'(pushes), 32'(exp_pushes));
        chk("frame pulses end", 32'(fd_pulses), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
